peripheral_sqrt_gen: RTL and testbench

//  Memory-mapped integer square-root peripheral. Parametrised successor to the single-operand sqr peripheral.

---
 rtl/peripheral_sqrt_gen.sv | 142 ++++++++++++++
 tb/tb_peripheral_sqrt_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_sqrt_gen.sv
// Memory-mapped integer square-root peripheral with a bit-serial root engine
// (one root bit per cycle), sticky done/overrun status and a registered interrupt.
module peripheral_sqrt_gen #(
  parameter int DATA_W = 32,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_in,
  input  logic              cs,
  input  logic [4:0]        addr,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] d_out,
  output logic              irq
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

  localparam logic [4:0] A_OPERAND = 5'h04;
  localparam logic [4:0] A_CTRL    = 5'h08;
  localparam logic [4:0] A_ROOT    = 5'h0C;
  localparam logic [4:0] A_REM     = 5'h10;
  localparam logic [4:0] A_STATUS  = 5'h14;

  typedef enum logic [0:0] {S_IDLE, S_CALC} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  operand_q;
  logic              irq_en_q, done_q, overrun_q;
  logic [HALF-1:0]   root_q;
  logic [HALF:0]     rem_q;
  logic [WIDTH-1:0]  op_sh;
  logic [HALF-1:0]   w_root;
  logic [HALF:0]     w_rem;
  logic [CW-1:0]     cnt;

  // Bus handshake: cs&rd and cs&wr are single-cycle strobes sampled on the
  // rising edge; there is no backpressure, and a read returns pre-write state.
  logic rd_en, wr_en, operand_wr, ctrl_wr, start_req, clr_req;
  logic busy, start_ok, last;

  assign rd_en      = cs && rd;
  assign wr_en      = cs && wr;
  assign operand_wr = wr_en && (addr == A_OPERAND);
  assign ctrl_wr    = wr_en && (addr == A_CTRL);
  assign start_req  = ctrl_wr && d_in[0];
  assign clr_req    = ctrl_wr && d_in[2];
  assign busy       = (state_q == S_CALC);
  assign start_ok   = start_req && !busy;
  assign last       = busy && (cnt == CW'(1));

  // One iteration: bring down the next operand pair and trial-subtract {root,01}.
  logic [1:0]      pair;
  logic [HALF+2:0] cat_rem, trial;
  logic [HALF:0]   diff, rem_nx;
  logic [HALF-1:0] root_nx;
  logic            ge;

  always_comb begin
    pair    = op_sh[WIDTH-1 -: 2];
    cat_rem = {w_rem, pair};
    trial   = {1'b0, w_root, 2'b01};
    ge      = (cat_rem >= trial);
    diff    = cat_rem[HALF:0] - trial[HALF:0];
    rem_nx  = ge ? diff : cat_rem[HALF:0];
    root_nx = {w_root[HALF-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_req) state_d = S_CALC;
      S_CALC:  if (cnt == CW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (addr)
      A_OPERAND: rd_data[WIDTH-1:0] = operand_q;
      A_CTRL:    rd_data[1]         = irq_en_q;
      A_ROOT:    rd_data[HALF-1:0]  = root_q;
      A_REM:     rd_data[HALF:0]    = rem_q;
      A_STATUS:  rd_data[2:0]       = {overrun_q, busy, done_q};
      default:   rd_data            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      root_q    <= '0;
      rem_q     <= '0;
      op_sh     <= '0;
      w_root    <= '0;
      w_rem     <= '0;
      cnt       <= '0;
      d_out     <= '0;
      irq       <= 1'b0;
    end else begin
      state_q <= state_d;
      irq     <= done_q & irq_en_q;
      if (rd_en)      d_out     <= rd_data;
      if (operand_wr) operand_q <= d_in[WIDTH-1:0];
      if (ctrl_wr)    irq_en_q  <= d_in[1];

      if (start_ok) begin
        op_sh  <= operand_q;
        w_root <= '0;
        w_rem  <= '0;
        cnt    <= CW'(HALF);
      end else if (busy) begin
        op_sh  <= op_sh << 2;
        w_root <= root_nx;
        w_rem  <= rem_nx;
        cnt    <= cnt - CW'(1);
      end

      // Result registers only move on the final iteration, never mid-calculation.
      if (last) begin
        root_q <= root_nx;
        rem_q  <= rem_nx;
      end

      if (last)                      done_q <= 1'b1;
      else if (start_ok || clr_req)  done_q <= 1'b0;

      if (start_req && busy) overrun_q <= 1'b1;
      else if (clr_req)      overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peripheral_sqrt_gen.sv
// Bench for peripheral_sqrt_gen: a cycle-level register model driven by plain
// integer square roots, directed cases from the datasheet and random bus traffic.
module tb_peripheral_sqrt_gen;

  localparam int DATA_W = 32;
  localparam int WIDTH  = 32;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] d_in  = '0;
  logic              cs    = 1'b0;
  logic [4:0]        addr  = '0;
  logic              rd    = 1'b0;
  logic              wr    = 1'b0;
  logic [DATA_W-1:0] d_out;
  logic              irq;

  // clock / reset
  always #5 clk = ~clk;

  peripheral_sqrt_gen #(.DATA_W(DATA_W), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out), .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic chk_on = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void isqrt(input logic [31:0] x, output logic [15:0] r, output logic [16:0] rm);
    longint unsigned acc, t;
    acc = 0;
    for (int b = 15; b >= 0; b--) begin
      t = acc | (64'd1 << b);
      if (t * t <= 64'(x)) acc = t;
    end
    r  = acc[15:0];
    rm = 17'(64'(x) - acc * acc);
  endfunction

  // register-level model
  logic [31:0] m_operand = '0;
  logic        m_irq_en = 1'b0, m_done = 1'b0, m_overrun = 1'b0, m_irq = 1'b0;
  logic [15:0] m_root = '0, m_pend_root = '0;
  logic [16:0] m_rem = '0, m_pend_rem = '0;
  logic [31:0] m_dout = '0;
  int          m_left = 0;
  logic        m_busy_pre, m_fin, m_irq_nx;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'h04:   return m_operand;
      5'h08:   return {30'b0, m_irq_en, 1'b0};
      5'h0C:   return {16'b0, m_root};
      5'h10:   return {15'b0, m_rem};
      5'h14:   return {29'b0, m_overrun, (m_left != 0), m_done};
      default: return 32'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_operand = '0; m_irq_en = 0; m_done = 0; m_overrun = 0; m_irq = 0;
      m_root = '0; m_rem = '0; m_dout = '0; m_left = 0;
    end else begin
      m_busy_pre = (m_left != 0);
      m_irq_nx   = m_done & m_irq_en;
      if (cs && rd) m_dout = model_read(addr);
      m_fin = m_busy_pre && (m_left == 1);
      if (m_busy_pre) m_left--;
      if (m_fin) begin
        m_root = m_pend_root;
        m_rem  = m_pend_rem;
        m_done = 1;
      end
      if (cs && wr) begin
        if (addr == 5'h04) m_operand = d_in;
        if (addr == 5'h08) begin
          m_irq_en = d_in[1];
          if (d_in[2]) begin
            m_overrun = 0;
            if (!m_fin) m_done = 0;
          end
          if (d_in[0]) begin
            if (m_busy_pre) m_overrun = 1;
            else begin
              isqrt(m_operand, m_pend_root, m_pend_rem);
              m_left = WIDTH / 2;
              m_done = 0;
            end
          end
        end
      end
      m_irq = m_irq_nx;
    end
  end

  // per-cycle output compare
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("d_out", d_out, m_dout);
      check("irq", irq, m_irq);
    end
  end

  // driver tasks (called at a falling edge, return at the next falling edge)
  task automatic bus_write(input logic [4:0] a, input logic [31:0] v);
    cs = 1; wr = 1; rd = 0; addr = a; d_in = v;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
    cs = 1; rd = 1; wr = 0; addr = a;
    @(negedge clk);
    v = d_out;
    cs = 0; rd = 0;
  endtask

  task automatic wait_done(output int cycles);
    logic [31:0] s;
    cycles = -1;
    s = '0;
    for (int k = 1; k <= 40; k++) begin
      bus_read(5'h14, s);
      if (s[0]) begin
        cycles = k - 1;
        break;
      end
    end
    if (cycles < 0) check("done_timeout", s[0], 1);
  endtask

  task automatic run_sqrt(input logic [31:0] x, output logic [31:0] r, output logic [31:0] rm, output int cyc);
    bus_write(5'h04, x);
    bus_write(5'h08, 32'h1);
    wait_done(cyc);
    bus_read(5'h0C, r);
    bus_read(5'h10, rm);
  endtask

  initial begin
    logic [31:0] v, r, rm, x;
    logic [15:0] er;
    logic [16:0] erm;
    int cyc;

    repeat (3) @(negedge clk);
    reset = 0;
    chk_on = 1;

    // reset state
    check("reset_irq", irq, 0);
    bus_read(5'h14, v); check("reset_status", v, 0);
    bus_read(5'h0C, v); check("reset_root", v, 0);
    bus_read(5'h04, v); check("reset_operand", v, 0);

    // basic results and latency
    run_sqrt(32'd17, r, rm, cyc);
    check("lat_17", cyc, 16);
    check("root_17", r, 4);
    check("rem_17", rm, 1);
    run_sqrt(32'd0, r, rm, cyc);
    check("root_0", r, 0);
    check("rem_0", rm, 0);
    run_sqrt(32'd1000000, r, rm, cyc);
    check("root_1e6", r, 1000);
    check("rem_1e6", rm, 0);
    run_sqrt(32'hFFFF_FFFF, r, rm, cyc);
    check("root_max", r, 32'hFFFF);
    check("rem_max", rm, 32'h1FFFE);

    // start while busy -> overrun, first result intact
    bus_write(5'h04, 32'd2000000);
    bus_write(5'h08, 32'h1);
    bus_write(5'h04, 32'd9);
    repeat (3) @(negedge clk);
    bus_write(5'h08, 32'h1);
    wait_done(cyc);
    bus_read(5'h0C, r); check("ovr_root", r, 1414);
    bus_read(5'h10, rm); check("ovr_rem", rm, 604);
    bus_read(5'h14, v); check("ovr_status", v, 32'b101);
    bus_write(5'h08, 32'h1);
    wait_done(cyc);
    bus_read(5'h0C, r); check("root_9", r, 3);
    bus_read(5'h10, rm); check("rem_9", rm, 0);
    bus_write(5'h08, 32'h4);
    bus_read(5'h14, v); check("clr_status", v, 0);

    // interrupt
    bus_write(5'h04, 32'd144);
    bus_write(5'h08, 32'h3);
    wait_done(cyc);
    @(negedge clk);
    check("irq_set", irq, 1);
    bus_read(5'h0C, r); check("root_144", r, 12);
    bus_write(5'h08, 32'h6);
    bus_read(5'h14, v); check("irq_clr_status", v, 0);
    check("irq_clr", irq, 0);
    bus_read(5'h08, v); check("ctrl_read", v, 2);

    // reset mid-calculation
    bus_write(5'h04, 32'd123456);
    bus_write(5'h08, 32'h1);
    repeat (5) @(negedge clk);
    #2 reset = 1;
    #1;
    check("rst_dout", d_out, 0);
    check("rst_irq", irq, 0);
    @(negedge clk);
    reset = 0;
    bus_read(5'h14, v); check("rst_status", v, 0);
    bus_read(5'h0C, v); check("rst_root", v, 0);
    run_sqrt(32'd49, r, rm, cyc);
    check("root_49", r, 7);
    check("rem_49", rm, 0);

    // random operands through the scoreboard queue
    for (int i = 0; i < 20; i++) begin
      x = (i < 2) ? ((i == 0) ? 32'hFFFF_FFFE : 32'h4000_0000) : $urandom;
      isqrt(x, er, erm);
      exp_q.push_back(WIDTH'(er));
      exp_q.push_back(WIDTH'(erm));
      run_sqrt(x, r, rm, cyc);
      check("rnd_lat", cyc, 16);
      check("rnd_root", r, exp_q.pop_front());
      check("rnd_rem", rm, exp_q.pop_front());
      check("rnd_invariant", 64'(r) * 64'(r) + 64'(rm), 64'(x));
    end

    // random bus traffic, checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      cs = ($urandom_range(0, 3) != 0);
      rd = $urandom_range(0, 1);
      wr = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: addr = 5'h04;
        1, 2: addr = 5'h08;
        3: addr = 5'h0C;
        4: addr = 5'h10;
        5: addr = 5'h14;
        6: addr = 5'h1C;
        default: addr = 5'($urandom_range(0, 31));
      endcase
      d_in = $urandom;
      if (addr == 5'h08) d_in[2] = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    cs = 0; rd = 0; wr = 0;
    repeat (20) @(negedge clk);
    bus_read(5'h14, v);
    check("final_not_busy", v[1], 0);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
